// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C sensor responder.
// Holds the FSM state enum, register map addresses, PART_ID value and a majority helper.
package i2c_resp_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    localparam logic [7:0] INT_STATUS  = 8'h00;
    localparam logic [7:0] FIFO_DATA   = 8'h07;
    localparam logic [7:0] MODE_CONFIG = 8'h09;
    localparam logic [7:0] PART_ID     = 8'hFF;
    localparam logic [7:0] PART_ID_VAL = 8'h15;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: 2-flop synchronizers, optional 3-sample majority filter
// (I2C_GLITCH_FILTER_EN), SCL edge pulses and START/STOP pulses.
// Ports: clk, rst_n, scl_in/sda_in (raw lines), sda (clean level),
//        scl_rise, scl_fall, start, stop (single-cycle pulses).
module i2c_bus_sync
    import i2c_resp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl;
    logic       scl_q;
    logic       sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
        end else begin
            scl_ff <= {scl_ff[0], scl_in};
            sda_ff <= {sda_ff[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    // Majority flips two cycles after the synchronizer output settles.
    logic [2:0] scl_h;
    logic [2:0] sda_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_ff[1]};
            sda_h <= {sda_h[1:0], sda_ff[1]};
        end
    end

    assign scl = maj3(scl_h);
    assign sda = maj3(sda_h);
`else
    assign scl = scl_ff[1];
    assign sda = sda_ff[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
        end
    end

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SDA may only move while SCL is steadily high for a bus condition.
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_sensor_responder.sv
// I2C target exposing a small register map and a 24-bit sample FIFO.
// Ports: clk, rst_n (async low), iic_0_scl, iic_0_sda (open drain), intr (low active),
//        sample_data/sample_de (FIFO push). Build option: I2C_GLITCH_FILTER_EN.
module i2c_sensor_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h57,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iic_0_scl,
    inout  wire         iic_0_sda,
    output logic        intr,
    input  logic [23:0] sample_data,
    input  logic        sample_de
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic          sda_s, scl_r, scl_f, start, stop;
    state_t        state, state_n;
    logic          sda_oe, sda_oe_n;
    logic          ptr_ld, wr_en, rd_done, tx_ld, tx_sh;
    logic [3:0]    cnt;
    logic [7:0]    shreg, ptr, mode, tx_byte, fifo_byte;
    logic [6:0]    txsr;
    logic          ack;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [23:0]   head;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [1:0]    bc;
    logic          ovf, nonempty, full, push, pop, drop, flush, byte_end, rx_bit;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (iic_0_scl),
        .sda_in   (iic_0_sda),
        .sda      (sda_s),
        .scl_rise (scl_r),
        .scl_fall (scl_f),
        .start    (start),
        .stop     (stop)
    );

    assign iic_0_sda = sda_oe ? 1'b0 : 1'bz;
    assign intr      = ~(nonempty | ovf);
    assign nonempty  = count != '0;
    assign full      = count == (AW + 1)'(FIFO_DEPTH);
    assign byte_end  = scl_f && (cnt == 4'd8);
    assign rx_bit    = (state == ADDR) || (state == REG) ||
                       (state == WDATA) || (state == RDATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
        end else begin
            state  <= state_n;
            sda_oe <= sda_oe_n;
        end
    end

    always_comb begin
        state_n  = state;
        sda_oe_n = sda_oe;
        ptr_ld   = 1'b0;
        wr_en    = 1'b0;
        rd_done  = 1'b0;
        tx_ld    = 1'b0;
        tx_sh    = 1'b0;
        if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else if (start) begin
            state_n  = ADDR;
            sda_oe_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR:
                    if (byte_end) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            state_n  = ADDR_ACK;
                            sda_oe_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                // shreg still holds the address byte here; bit 0 is R/W.
                ADDR_ACK:
                    if (scl_f) begin
                        if (shreg[0]) begin
                            state_n  = RDATA;
                            tx_ld    = 1'b1;
                            sda_oe_n = ~tx_byte[7];
                        end else begin
                            state_n  = REG;
                            sda_oe_n = 1'b0;
                        end
                    end
                REG:
                    if (byte_end) begin
                        state_n  = REG_ACK;
                        sda_oe_n = 1'b1;
                        ptr_ld   = 1'b1;
                    end
                REG_ACK:
                    if (scl_f) begin
                        state_n  = WDATA;
                        sda_oe_n = 1'b0;
                    end
                WDATA:
                    if (byte_end) begin
                        state_n  = WDATA_ACK;
                        sda_oe_n = 1'b1;
                        wr_en    = 1'b1;
                    end
                WDATA_ACK:
                    if (scl_f) begin
                        state_n  = WDATA;
                        sda_oe_n = 1'b0;
                    end
                RDATA:
                    if (scl_f) begin
                        if (cnt == 4'd8) begin
                            state_n  = RDATA_ACK;
                            sda_oe_n = 1'b0;
                        end else begin
                            tx_sh    = 1'b1;
                            sda_oe_n = ~txsr[6];
                        end
                    end
                // Byte side effects land on the ACK/NACK sample so the
                // next byte, loaded on the following fall, already sees them.
                RDATA_ACK: begin
                    rd_done = scl_r;
                    if (scl_f) begin
                        if (ack) begin
                            state_n  = RDATA;
                            tx_ld    = 1'b1;
                            sda_oe_n = ~tx_byte[7];
                        end else begin
                            state_n  = IDLE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
            txsr  <= '0;
            ack   <= 1'b0;
        end else begin
            if (start || stop || (state_n != state)) cnt <= '0;
            else if (scl_r && rx_bit) cnt <= cnt + 4'd1;
            if (scl_r && rx_bit && (state != RDATA))
                shreg <= {shreg[6:0], sda_s};
            if (tx_ld) txsr <= tx_byte[6:0];
            else if (tx_sh) txsr <= {txsr[5:0], 1'b0};
            if (scl_r && (state == RDATA_ACK)) ack <= ~sda_s;
        end
    end

    assign head = mem[rp];

    always_comb begin
        unique case (bc)
            2'd0:    fifo_byte = head[23:16];
            2'd1:    fifo_byte = head[15:8];
            default: fifo_byte = head[7:0];
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        case (ptr)
            INT_STATUS:  tx_byte = {ovf, nonempty, 6'b0};
            FIFO_DATA:   if (nonempty) tx_byte = fifo_byte;
            MODE_CONFIG: tx_byte = mode;
            PART_ID:     tx_byte = PART_ID_VAL;
            default:     tx_byte = 8'h00;
        endcase
    end

    assign flush = wr_en && (ptr == MODE_CONFIG) && shreg[6];
    assign drop  = sample_de && full;
    assign push  = sample_de && !full && !flush;
    assign pop   = rd_done && (ptr == FIFO_DATA) && nonempty && (bc == 2'd2);

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= sample_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (drop) ovf <= 1'b1;
            else if (rd_done && (ptr == INT_STATUS)) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc   <= '0;
            ptr  <= '0;
            mode <= '0;
        end else begin
            if (start || stop || flush) bc <= '0;
            else if (rd_done && (ptr == FIFO_DATA) && nonempty)
                bc <= (bc == 2'd2) ? 2'd0 : bc + 2'd1;
            if (ptr_ld) ptr <= shreg;
            else if ((wr_en || rd_done) && (ptr != FIFO_DATA))
                ptr <= ptr + 8'd1;
            if (wr_en && (ptr == MODE_CONFIG)) mode <= shreg & 8'hBF;
        end
    end

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Bench for i2c_sensor_responder: bit-level I2C initiator, sample pushes,
// and a queue-based model of the register map and sample FIFO.
module tb_i2c_sensor_responder;

    localparam int P = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_scl, m_sda;
    logic        intr;
    logic [23:0] sample_data;
    logic        sample_de;
    wire         sda_bus;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_sensor_responder #(
        .DEV_ADDR   (7'h57),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iic_0_scl   (m_scl),
        .iic_0_sda   (sda_bus),
        .intr        (intr),
        .sample_data (sample_data),
        .sample_de   (sample_de)
    );

    int ntests = 0;
    int nfail  = 0;
    int low_cnt = 0;
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && m_sda && sda_bus !== 1'b1) low_cnt <= low_cnt + 1;
    end

    logic [23:0] mq[$];
    logic        movf;
    logic [7:0]  mptr, mmode, last_rd;
    int          mbidx;
    logic [7:0]  wdat [4];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_rd();
        logic [7:0] r;
        r = 8'h00;
        if (mptr == 8'h00) begin
            r = {movf, mq.size() != 0, 6'b0};
            movf = 1'b0;
        end else if (mptr == 8'h07) begin
            if (mq.size() != 0) begin
                r = 8'(mq[0] >> (8 * (2 - mbidx)));
                if (mbidx == 2) begin
                    void'(mq.pop_front());
                    mbidx = 0;
                end else begin
                    mbidx++;
                end
            end
        end else if (mptr == 8'h09) begin
            r = mmode;
        end else if (mptr == 8'hFF) begin
            r = 8'h15;
        end
        if (mptr != 8'h07) mptr = mptr + 8'd1;
        return r;
    endfunction

    function automatic void m_wr(input logic [7:0] b);
        if (mptr == 8'h09) begin
            mmode = b & 8'hBF;
            if (b[6]) begin
                mq.delete();
                movf = 1'b0;
            end
        end
        if (mptr != 8'h07) mptr = mptr + 8'd1;
    endfunction

    function automatic void m_reset();
        mq.delete();
        movf  = 1'b0;
        mptr  = 8'h00;
        mmode = 8'h00;
        mbidx = 0;
    endfunction

    function automatic logic m_intr();
        return !(mq.size() != 0 || movf);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [23:0] s);
        sample_data = s;
        sample_de   = 1'b1;
        tick(1);
        sample_de   = 1'b0;
        if (mq.size() == 4) movf = 1'b1;
        else mq.push_back(s);
        tick(1);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(P);
        m_scl = 1'b1; tick(P);
        m_sda = 1'b0; tick(P);
        m_scl = 1'b0; tick(P);
        mbidx = 0;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(P);
        m_scl = 1'b1; tick(P);
        m_sda = 1'b1; tick(P);
        mbidx = 0;
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    tick(P);
        m_scl = 1'b1; tick(P);
        m_scl = 1'b0; tick(P);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; tick(P);
        m_scl = 1'b1; tick(P / 2);
        b = sda_bus;  tick(P - P / 2);
        m_scl = 1'b0; tick(P);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic nak;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(nak);
        acked = !nak;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic give_ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            read_bit(v);
            b[i] = v;
        end
        write_bit(!give_ack);
    endtask

    task automatic wr_chk(input logic [7:0] b, input string tag);
        logic a;
        write_byte(b, a);
        check(tag, 32'(a), 32'd1);
    endtask

    task automatic do_write(input logic [7:0] ra, input int n);
        i2c_start();
        wr_chk(8'hAE, "ack_addr_w");
        wr_chk(ra, "ack_reg");
        mptr = ra;
        for (int i = 0; i < n; i++) begin
            wr_chk(wdat[i], "ack_wdata");
            m_wr(wdat[i]);
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [7:0] ra, input int n);
        logic [7:0] b;
        logic [7:0] e;
        i2c_start();
        wr_chk(8'hAE, "ack_addr_w");
        wr_chk(ra, "ack_reg");
        mptr = ra;
        i2c_start();
        wr_chk(8'hAF, "ack_addr_r");
        for (int i = 0; i < n; i++) begin
            read_byte(b, i != n - 1);
            e = m_rd();
            check($sformatf("rd_%02h_%0d", ra, i), 32'(b), 32'(e));
            last_rd = b;
        end
        i2c_stop();
    endtask

    initial begin
        int          k;
        int          sel;
        int          lc;
        logic        a;
        logic [7:0]  ra;
        logic [7:0]  regs [5];
        logic        bit_v;

        regs[0] = 8'h00; regs[1] = 8'h07; regs[2] = 8'h09;
        regs[3] = 8'hFF; regs[4] = 8'h00;

        m_scl = 1'b1;
        m_sda = 1'b1;
        sample_de = 1'b0;
        sample_data = '0;
        rst_n = 1'b0;
        m_reset();
        tick(3);
        check("reset_intr", 32'(intr), 32'd1);
        check("reset_sda", 32'(sda_bus), 32'd1);
        rst_n = 1'b1;
        tick(4);

        do_read(8'h09, 1);
        do_read(8'h00, 1);

        // Part ID read with repeated start
        do_read(8'hFF, 1);
        check("part_id", 32'(last_rd), 32'h15);

        // Two samples read back as six bytes
        push(24'h123456);
        push(24'hABCDEF);
        check("intr_nonempty", 32'(intr), 32'd0);
        do_read(8'h07, 6);
        check("last_byte", 32'(last_rd), 32'hEF);
        check("intr_drained", 32'(intr), 32'd1);

        // Overflow with five pushes into four entries
        for (int i = 0; i < 5; i++) push(24'($urandom()));
        check("intr_ovf", 32'(intr), 32'd0);
        do_read(8'h00, 1);
        check("int_status_ovf", 32'(last_rd), 32'hC0);
        do_read(8'h00, 1);
        check("int_status_clr", 32'(last_rd), 32'h40);
        do_read(8'h07, 12);
        do_read(8'h07, 3);
        check("empty_fifo_byte", 32'(last_rd), 32'h00);
        check("intr_after_ovf", 32'(intr), 32'd1);

        // Wrong address stays silent
        lc = low_cnt;
        mon_en = 1'b1;
        i2c_start();
        write_byte(8'hA0, a);
        check("wrong_addr_nack", 32'(a), 32'd0);
        write_byte(8'h07, a);
        check("wrong_addr_nack2", 32'(a), 32'd0);
        i2c_stop();
        mon_en = 1'b0;
        tick(2);
        check("wrong_addr_hiz", 32'(low_cnt - lc), 32'd0);
        do_read(8'hFF, 1);

        // Partial sample read is re-read from byte 0
        push(24'($urandom()));
        do_read(8'h07, 2);
        do_read(8'h07, 3);
        check("partial_popped", 32'(intr), 32'd1);
        push(24'($urandom()));
        push(24'($urandom()));
        wdat[0] = 8'h40;
        do_write(8'h09, 1);
        check("flush_intr", 32'(intr), 32'd1);
        do_read(8'h09, 1);
        check("mode_bit6_clear", 32'(last_rd), 32'h00);
        wdat[0] = 8'h05;
        do_write(8'h09, 1);
        do_read(8'h09, 1);

        // Randomised mix of pushes, reads and writes
        for (int it = 0; it < 8; it++) begin
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) push(24'($urandom()));
            sel = $urandom_range(0, 4);
            ra = regs[sel];
            if (sel == 4) ra = 8'($urandom());
            if ($urandom_range(0, 1) == 1) begin
                do_read(ra, $urandom_range(1, 4));
            end else begin
                for (int j = 0; j < 2; j++) wdat[j] = 8'($urandom());
                do_write(ra, 2);
            end
            check("rand_intr", 32'(intr), 32'(m_intr()));
        end

        // Reset in the middle of a FIFO read
        wdat[0] = 8'h40;
        do_write(8'h09, 1);
        push({8'h00, 16'($urandom())});
        i2c_start();
        wr_chk(8'hAE, "ack_addr_w");
        wr_chk(8'h07, "ack_reg");
        i2c_start();
        wr_chk(8'hAF, "ack_addr_r");
        for (int i = 0; i < 3; i++) read_bit(bit_v);
        check("mid_read_drive", 32'(sda_bus), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_release_sda", 32'(sda_bus), 32'd1);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(4);
        m_reset();
        check("rst_intr", 32'(intr), 32'd1);
        rst_n = 1'b1;
        tick(2 * P);
        do_read(8'hFF, 1);
        check("post_rst_part_id", 32'(last_rd), 32'h15);
        do_read(8'h00, 1);
        check("post_rst_status", 32'(last_rd), 32'h00);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
